// File: rtl/trap_sequencer.sv
// Interrupt entry/return sequencer: STATUS/INTMASK/PEND/EPC CSRs, pipeline flush handshake, PC redirect.
// Optional IRQ_EDGE_EN: rising-edge interrupt capture into PEND; default build is level-sensitive.
module trap_sequencer #(
  parameter int              NUM_IRQ     = 8,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] VECTOR_BASE = 32'h0000_1000,
  localparam int             CW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               csr_we,
  input  logic [1:0]         csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [XLEN-1:0]    pc_in,
  output logic               flush_req,
  input  logic               flush_ack,
  input  logic               eret,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               in_trap,
  output logic [CW-1:0]      int_cause,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_INTMASK = 2'd1;
  localparam logic [1:0] ADDR_PEND    = 2'd2;
  localparam logic [1:0] ADDR_EPC     = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_VECTOR, S_HANDLER, S_RETURN} state_e;

  state_e             state_q;
  logic               ie_q, exl_q, pie_q;
  logic               ie_d, exl_d, pie_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic               flush_req_q, redirect_valid_q;
  logic [XLEN-1:0]    redirect_pc_q;
  logic [NUM_IRQ-1:0] irq_ack_q;

  logic [NUM_IRQ-1:0] masked;
  logic               take, ack_edge, eret_edge;

  assign masked    = pend_q & mask_q;
  assign take      = (|masked) & ie_q & ~exl_q;
  assign ack_edge  = (state_q == S_FLUSH) && flush_ack;
  assign eret_edge = (state_q == S_HANDLER) && eret;

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cause_d = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) cause_d = CW'(i);
    end
  end

  // CSR write first, hardware trap entry/return updates afterwards so they take precedence.
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    pie_d  = pie_q;
    mask_d = mask_q;
    epc_d  = epc_q;
    if (csr_we) begin
      case (csr_addr)
        ADDR_STATUS:  {pie_d, exl_d, ie_d} = csr_wdata[2:0];
        ADDR_INTMASK: mask_d = csr_wdata[NUM_IRQ-1:0];
        ADDR_EPC:     epc_d = csr_wdata;
        default:      ;
      endcase
    end
    if (ack_edge) begin
      epc_d = pc_in;
      pie_d = ie_q;
      ie_d  = 1'b0;
      exl_d = 1'b1;
    end else if (eret_edge) begin
      ie_d  = pie_q;
      exl_d = 1'b0;
      pie_d = 1'b0;
    end
  end

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q;

  // New rising edges are OR-ed in last so a set beats a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    if (csr_we && csr_addr == ADDR_PEND) pend_d = pend_d & ~csr_wdata[NUM_IRQ-1:0];
    if (ack_edge) pend_d[cause_q] = 1'b0;
    pend_d = pend_d | (irq_in & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq_in;
  end
`else
  assign pend_d = irq_in;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_STATUS:  csr_rdata = XLEN'({pie_q, exl_q, ie_q});
      ADDR_INTMASK: csr_rdata = XLEN'(mask_q);
      ADDR_PEND:    csr_rdata = XLEN'(pend_q);
      ADDR_EPC:     csr_rdata = epc_q;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q          <= S_IDLE;
      ie_q             <= 1'b0;
      exl_q            <= 1'b0;
      pie_q            <= 1'b0;
      mask_q           <= '0;
      pend_q           <= '0;
      epc_q            <= '0;
      cause_q          <= '0;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      irq_ack_q        <= '0;
    end else begin
      ie_q             <= ie_d;
      exl_q            <= exl_d;
      pie_q            <= pie_d;
      mask_q           <= mask_d;
      pend_q           <= pend_d;
      epc_q            <= epc_d;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      irq_ack_q        <= '0;
      case (state_q)
        S_IDLE: begin
          if (take) begin
            cause_q     <= cause_d;
            flush_req_q <= 1'b1;
            state_q     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_ack) begin
            irq_ack_q        <= NUM_IRQ'(1) << cause_q;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= VECTOR_BASE + XLEN'({cause_q, 2'b00});
            state_q          <= S_VECTOR;
          end else begin
            flush_req_q <= 1'b1;
          end
        end
        S_VECTOR: state_q <= S_HANDLER;
        S_HANDLER: begin
          if (eret) begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= epc_q;
            state_q          <= S_RETURN;
          end
        end
        S_RETURN: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign flush_req      = flush_req_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign in_trap        = exl_q;
  assign int_cause      = cause_q;
  assign irq_ack        = irq_ack_q;

endmodule
